// File: rtl/filo_frame_reverser.sv
// filo_frame_reverser: pushes each incoming frame into an external FILO stack,
// then pops it back out so the downstream sink sees the words in reverse order.
// Frames longer than the stack (2**AddressDepth words) are reversed in chunks.
// Optional feature macro: FILO_REVERSER_STATS_EN adds frame_cnt / split_cnt ports.
module filo_frame_reverser #(
  parameter int AddressDepth = 4,
  parameter int DataWide     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DataWide-1:0] in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DataWide-1:0] out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                stk_rst_n,
  output logic                stk_cs,
  output logic                stk_push_pop,
  output logic [DataWide-1:0] stk_data_in,
  input  logic [DataWide-1:0] stk_data_out,
  input  logic                stk_full,
  input  logic                stk_empty,
`ifdef FILO_REVERSER_STATS_EN
  output logic [15:0]         frame_cnt,
  output logic [15:0]         split_cnt,
`endif
  output logic                proto_err
);

  localparam int DEPTH = 1 << AddressDepth;
  localparam logic [AddressDepth:0] DEPTH_C = (AddressDepth+1)'(DEPTH);

  typedef enum logic [1:0] {FILL, POP, CAPTURE, HOLD} state_t;

  state_t                state;
  logic [AddressDepth:0] count;
  logic [AddressDepth:0] count_inc;
  logic                  last_seen;
  logic                  push_acc;
  logic                  pop_go;
  logic                  chunk_full;

  // Stack-side strobes are combinational so a push lands in the same cycle as the accept.
  assign stk_rst_n    = ~rst;
  assign in_ready     = (state == FILL) & ~stk_full & (count < DEPTH_C);
  assign push_acc     = in_valid & in_ready;
  assign pop_go       = (state == POP) & ~stk_empty;
  assign stk_cs       = ~rst & (push_acc | pop_go);
  assign stk_push_pop = (state == FILL);
  assign stk_data_in  = in_data;
  assign count_inc    = count + 1'b1;
  // Chunk closed by the stack limit rather than by the frame's last word.
  assign chunk_full   = push_acc & ~in_last & (count_inc == DEPTH_C);

  // Main control FSM: fill, then pop/capture/hold once per output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      last_seen <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (push_acc) begin
            count <= count_inc;
            if (in_last) begin
              last_seen <= 1'b1;
              state     <= POP;
            end else if (count_inc == DEPTH_C) begin
              last_seen <= 1'b0;
              state     <= POP;
            end
          end
        end
        POP: begin
          if (stk_empty) begin
            // Stack disagrees with our count: flag it and resynchronise to empty.
            proto_err <= 1'b1;
            count     <= '0;
            last_seen <= 1'b0;
            state     <= FILL;
          end else begin
            count <= count - 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          out_data  <= stk_data_out;
          out_valid <= 1'b1;
          out_last  <= last_seen & (count == '0);
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (count == '0) begin
              last_seen <= 1'b0;
              state     <= FILL;
            end else begin
              state <= POP;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef FILO_REVERSER_STATS_EN
  // Statistics: frames completed downstream and chunks forced by the stack limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      split_cnt <= '0;
    end else begin
      if ((state == HOLD) & out_valid & out_ready & out_last) frame_cnt <= frame_cnt + 1'b1;
      if (chunk_full) split_cnt <= split_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_filo_frame_reverser.sv
// Bench for filo_frame_reverser: behavioural FILO stack model plus a scoreboard of
// expected reversed words, checked at each downstream handshake.
module tb_filo_frame_reverser;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       stk_rst_n, stk_cs, stk_push_pop;
  logic [7:0] stk_data_in, stk_data_out;
  logic       stk_full, stk_empty;
  logic       proto_err;
  logic       force_empty;
`ifdef FILO_REVERSER_STATS_EN
  logic [15:0] frame_cnt, split_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];   // {last, data}

  always #5 clk = ~clk;

  filo_frame_reverser #(.AddressDepth(4), .DataWide(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .stk_rst_n(stk_rst_n), .stk_cs(stk_cs), .stk_push_pop(stk_push_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_full(stk_full), .stk_empty(stk_empty),
`ifdef FILO_REVERSER_STATS_EN
    .frame_cnt(frame_cnt), .split_cnt(split_cnt),
`endif
    .proto_err(proto_err)
  );

  // Stack model: 16 entries, popped word appears the cycle after the pop edge.
  logic [7:0] mem [0:15];
  int sp = 0;
  always @(posedge clk) begin
    if (!stk_rst_n) sp <= 0;
    else if (stk_cs) begin
      if (stk_push_pop) begin
        if (sp < 16) begin
          mem[sp[3:0]] <= stk_data_in;
          sp <= sp + 1;
        end
      end else if (sp > 0) begin
        stk_data_out <= mem[4'(sp - 1)];
        sp <= sp - 1;
      end
    end
  end
  assign stk_full  = (sp == 16);
  assign stk_empty = (sp == 0) | force_empty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream monitor: every handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_out", {23'd0, out_last, out_data}, 32'h1ff);
      else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
        check("out_last", {31'd0, out_last}, {31'd0, e[8]});
      end
    end
  end

  // Queue expected output: 16-word chunks, each reversed, last only on the final chunk.
  task automatic expect_frame(input logic [7:0] base, input int n);
    for (int s = 0; s < n; s += 16) begin
      int len;
      len = (n - s < 16) ? n - s : 16;
      for (int j = len - 1; j >= 0; j--)
        sb.push_back({((s + len == n) && (j == 0)), 8'(base + 8'(s + j))});
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input bit exp_out);
    if (exp_out) expect_frame(base, n);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int guard;
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      in_last  = (i == n - 1);
      guard    = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 500);
      if (!acc) check("in_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] fc0, sc0;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; force_empty = 1'b0;

    // 1. reset state
    cycles(2);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stk_cs",    {31'd0, stk_cs},    32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);
    check("rst_stk_rst_n", {31'd0, stk_rst_n}, 32'd0);
    rst = 1'b0;
    cycles(1);

    // 2. three-word frame, in_ready low while draining
    send_frame(8'h01, 3, 1'b1);
    check("drain_in_ready0", {31'd0, in_ready}, 32'd0);
    cycles(1);
    check("drain_in_ready1", {31'd0, in_ready}, 32'd0);
    wait_drain();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 3. 20-word frame splits into a 16-word chunk and a 4-word chunk
`ifdef FILO_REVERSER_STATS_EN
    fc0 = frame_cnt; sc0 = split_cnt;
`else
    fc0 = '0; sc0 = '0;
`endif
    send_frame(8'h00, 20, 1'b1);
    wait_drain();
`ifdef FILO_REVERSER_STATS_EN
    check("split_cnt", {16'd0, split_cnt}, {16'd0, 16'(sc0 + 16'd1)});
    check("frame_cnt", {16'd0, frame_cnt}, {16'd0, 16'(fc0 + 16'd1)});
`endif

    // 4. backpressure in HOLD: output stable, no stack access
    out_ready = 1'b0;
    send_frame(8'h20, 3, 1'b1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("hold_reach", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data",  {24'd0, out_data}, {24'd0, sb[0][7:0]});
      check("hold_no_cs", {31'd0, stk_cs}, 32'd0);
    end
    out_ready = 1'b1;
    wait_drain();

    // 5. stack reports empty while count=2 -> sticky protocol error, back to FILL
    force_empty = 1'b1;
    send_frame(8'h40, 2, 1'b0);
    check("perr_no_pop", {31'd0, stk_cs}, 32'd0);
    cycles(1);
    force_empty = 1'b0;
    check("perr_set",    {31'd0, proto_err}, 32'd1);
    check("perr_fill",   {31'd0, in_ready},  32'd1);
    cycles(3);
    check("perr_sticky", {31'd0, proto_err}, 32'd1);
    check("perr_no_out", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    cycles(2);
    check("perr_cleared", {31'd0, proto_err}, 32'd0);
    rst = 1'b0;
    cycles(1);

    // 6. reset mid-drain of an 8-word frame, then a clean 2-word frame
    send_frame(8'h50, 8, 1'b1);
    guard = 0;
    while (sb.size() > 6 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("mid_drain_reach", sb.size(), 32'd6);
    rst = 1'b1;
    sb.delete();
    cycles(1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    cycles(1);
    rst = 1'b0;
    cycles(1);
    send_frame(8'h0A, 2, 1'b1);
    wait_drain();
    check("final_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
